imem_arbiter: RTL



---
 rtl/imem_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: the program loader owns the memory in BOOT.
// In RUN, fetch has priority, and a starvation counter guarantees the loader a slot.
module imem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_stall,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_misalign,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              load_gnt,
  input  logic              load_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              boot_mode
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic [3:0]        starve_cnt;
  logic              starved;
  logic [DATA_W-1:0] rdata_hold;
  logic              unused_addr_bits;

  // Byte-address bits above the memory range are dropped, so fetch addresses wrap.
  assign unused_addr_bits = ^fetch_addr[31:ADDR_W+2];

  assign starved = load_req && (starve_cnt == 4'(MAX_STARVE));

  // Grants are suppressed during reset so no access is issued in a reset cycle.
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (!reset) begin
      case (state)
        BOOT: load_gnt = load_req;
        RUN: begin
          fetch_gnt = fetch_req & ~starved;
          load_gnt  = load_req & ~(fetch_req & ~starved);
        end
        default: ;
      endcase
    end
  end

  assign fetch_stall = fetch_req & ~fetch_gnt;
  assign mem_en      = fetch_gnt | load_gnt;
  assign mem_we      = load_gnt;
  assign mem_addr    = load_gnt ? load_addr : fetch_addr[ADDR_W+1:2];
  assign mem_wdata   = load_gnt ? load_wdata : '0;

  // The memory already registers its read data, so it is forwarded in the valid cycle
  // and captured only to hold the last instruction while fetch_rvalid is low.
  assign fetch_rdata = fetch_rvalid ? mem_rdata : rdata_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      boot_mode      <= 1'b1;
      starve_cnt     <= '0;
      fetch_rvalid   <= 1'b0;
      fetch_misalign <= 1'b0;
      rdata_hold     <= '0;
    end else begin
      fetch_rvalid <= fetch_gnt;
      if (fetch_gnt) begin
        fetch_misalign <= |fetch_addr[1:0];
      end
      if (fetch_rvalid) begin
        rdata_hold <= mem_rdata;
      end
      case (state)
        BOOT: begin
          starve_cnt <= '0;
          if (load_done) begin
            state     <= RUN;
            boot_mode <= 1'b0;
          end
        end
        RUN: begin
          if (load_req && !load_gnt) begin
            if (starve_cnt != 4'(MAX_STARVE)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
